// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, stop-bit encodings and the
// stop-period length helper used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_t;

  localparam logic [1:0] SB_1   = 2'b00;
  localparam logic [1:0] SB_1P5 = 2'b01;
  localparam logic [1:0] SB_2   = 2'b10;

  // 2'b11 is treated as two stop bits
  function automatic int unsigned stop_ticks(input logic [1:0] stop_bits,
                                             input int unsigned ovrsampling);
    case (stop_bits)
      SB_1:    return ovrsampling;
      SB_1P5:  return (3 * ovrsampling) / 2;
      default: return 2 * ovrsampling;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_engine.sv
// UART transmitter: serialises one latched character per request using the
// shared oversampling tick; frame format is captured at accept time.
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int unsigned OVRSAMPLING = 16,
  parameter int unsigned SB_TICK_W   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  input  logic       data_bit,
  input  logic       parity_en,
  input  logic       parity_pol,
  input  logic [1:0] stop_bits,
  output logic       tx_done_tick,
  output logic       tx_busy,
  output logic       tx
);

  localparam logic [SB_TICK_W-1:0] BIT_END = SB_TICK_W'(OVRSAMPLING - 1);

  uart_state_t          state;
  logic [SB_TICK_W-1:0] s_cnt;
  logic [2:0]           n;
  logic [7:0]           shift;
  logic                 data_bit_r;
  logic                 parity_en_r;
  logic                 parity_r;
  logic [1:0]           stop_bits_r;

  logic [SB_TICK_W-1:0] stop_end;
  logic [2:0]           last_bit;
  logic                 parity_calc;

  always_comb begin
    stop_end    = SB_TICK_W'(stop_ticks(stop_bits_r, OVRSAMPLING) - 1);
    last_bit    = data_bit_r ? 3'd7 : 3'd6;
    // even parity is the XOR of the transmitted data bits, odd is its inverse
    parity_calc = (^(data_bit ? din : {1'b0, din[6:0]})) ^ ~parity_pol;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s_cnt        <= '0;
      n            <= '0;
      shift        <= '0;
      data_bit_r   <= 1'b0;
      parity_en_r  <= 1'b0;
      parity_r     <= 1'b0;
      stop_bits_r  <= '0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_start) begin
            shift       <= din;
            data_bit_r  <= data_bit;
            parity_en_r <= parity_en;
            parity_r    <= parity_calc;
            stop_bits_r <= stop_bits;
            s_cnt       <= '0;
            tx          <= 1'b0;
            tx_busy     <= 1'b1;
            state       <= START;
          end
        end
        START: if (s_tick) begin
          if (s_cnt == BIT_END) begin
            s_cnt <= '0;
            n     <= '0;
            tx    <= shift[0];
            state <= DATA;
          end else begin
            s_cnt <= s_cnt + SB_TICK_W'(1);
          end
        end
        DATA: if (s_tick) begin
          if (s_cnt == BIT_END) begin
            s_cnt <= '0;
            shift <= shift >> 1;
            if (n == last_bit) begin
              if (parity_en_r) begin
                tx    <= parity_r;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              n  <= n + 3'd1;
              tx <= shift[1];
            end
          end else begin
            s_cnt <= s_cnt + SB_TICK_W'(1);
          end
        end
        PARITY: if (s_tick) begin
          if (s_cnt == BIT_END) begin
            s_cnt <= '0;
            tx    <= 1'b1;
            state <= STOP;
          end else begin
            s_cnt <= s_cnt + SB_TICK_W'(1);
          end
        end
        STOP: if (s_tick) begin
          if (s_cnt == stop_end) begin
            s_cnt        <= '0;
            tx_done_tick <= 1'b1;
            tx_busy      <= 1'b0;
            state        <= IDLE;
          end else begin
            s_cnt <= s_cnt + SB_TICK_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
